// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard control bus: hazard inputs from ID/EX/MEM/IF and
// the stall/flush/MDU-start/status outputs of the sequencing controller.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_IDX_W = 5,
  parameter int unsigned CNT_W     = 32
);
  logic                 id_rs1_en_i;
  logic [REG_IDX_W-1:0] id_rs1_index_i;
  logic                 id_rs2_en_i;
  logic [REG_IDX_W-1:0] id_rs2_index_i;
  logic                 id2ex_valid_i;
  logic                 id2ex_mem_read_i;
  logic                 id2ex_mdu_i;
  logic                 id2ex_rd_en_i;
  logic [REG_IDX_W-1:0] id2ex_rd_index_i;
  logic                 ex_redirect_i;
  logic                 if_ready_i;
  logic                 mem_req_i;
  logic                 mem_ready_i;
  logic                 mdu_done_i;

  logic                 pc_stall_o;
  logic                 if2id_stall_o;
  logic                 id2ex_stall_o;
  logic                 ex2mem_stall_o;
  logic                 if2id_flush_o;
  logic                 id2ex_flush_o;
  logic                 ex2mem_flush_o;
  logic                 mem2wb_flush_o;
  logic                 mdu_start_o;
  logic [1:0]           ctrl_state_o;
  logic [CNT_W-1:0]     stall_cnt_o;

  // Controller side
  modport master (
    input  id_rs1_en_i, id_rs1_index_i, id_rs2_en_i, id_rs2_index_i,
           id2ex_valid_i, id2ex_mem_read_i, id2ex_mdu_i, id2ex_rd_en_i,
           id2ex_rd_index_i, ex_redirect_i, if_ready_i, mem_req_i,
           mem_ready_i, mdu_done_i,
    output pc_stall_o, if2id_stall_o, id2ex_stall_o, ex2mem_stall_o,
           if2id_flush_o, id2ex_flush_o, ex2mem_flush_o, mem2wb_flush_o,
           mdu_start_o, ctrl_state_o, stall_cnt_o
  );

  // Pipeline side
  modport slave (
    output id_rs1_en_i, id_rs1_index_i, id_rs2_en_i, id_rs2_index_i,
           id2ex_valid_i, id2ex_mem_read_i, id2ex_mdu_i, id2ex_rd_en_i,
           id2ex_rd_index_i, ex_redirect_i, if_ready_i, mem_req_i,
           mem_ready_i, mdu_done_i,
    input  pc_stall_o, if2id_stall_o, id2ex_stall_o, ex2mem_stall_o,
           if2id_flush_o, id2ex_flush_o, ex2mem_flush_o, mem2wb_flush_o,
           mdu_start_o, ctrl_state_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencing controller: load-use bubbles, MDU occupancy,
// data/fetch wait states and EX redirects with stale-fetch discard.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_IDX_W = 5,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_MDU  = 2'd1,
    ST_KILL = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [REG_IDX_W-1:0] rs1_idx, rs2_idx, rd_idx;
  logic                 mem_wait, load_use, mdu_issue;
  logic                 pc_stall;

  assign rs1_idx = bus.id_rs1_index_i;
  assign rs2_idx = bus.id_rs2_index_i;
  assign rd_idx  = bus.id2ex_rd_index_i;

  assign mem_wait  = bus.mem_req_i & ~bus.mem_ready_i;
  assign mdu_issue = bus.id2ex_valid_i & bus.id2ex_mdu_i;
  assign load_use  = bus.id2ex_valid_i & bus.id2ex_mem_read_i & bus.id2ex_rd_en_i
                   & (rd_idx != REG_IDX_W'(0))
                   & ((bus.id_rs1_en_i & (rs1_idx == rd_idx))
                    | (bus.id_rs2_en_i & (rs2_idx == rd_idx)));

  // State and stall counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next state; a memory wait freezes every transition, including a pending MDU release
  always_comb begin
    state_d = state_q;
    if (!mem_wait) begin
      unique case (state_q)
        ST_KILL: if (bus.if_ready_i) state_d = ST_RUN;
        ST_MDU:  if (bus.mdu_done_i) state_d = ST_RUN;
        ST_RUN: begin
          if (mdu_issue)                              state_d = ST_MDU;
          else if (bus.ex_redirect_i && !bus.if_ready_i) state_d = ST_KILL;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Per-cycle stall/flush outputs in priority order; reset forces bubbles everywhere
  always_comb begin
    pc_stall           = 1'b0;
    bus.if2id_stall_o  = 1'b0;
    bus.id2ex_stall_o  = 1'b0;
    bus.ex2mem_stall_o = 1'b0;
    bus.if2id_flush_o  = 1'b0;
    bus.id2ex_flush_o  = 1'b0;
    bus.ex2mem_flush_o = 1'b0;
    bus.mem2wb_flush_o = 1'b0;
    bus.mdu_start_o    = 1'b0;
    if (rst) begin
      bus.if2id_flush_o  = 1'b1;
      bus.id2ex_flush_o  = 1'b1;
      bus.ex2mem_flush_o = 1'b1;
      bus.mem2wb_flush_o = 1'b1;
    end else if (mem_wait) begin
      pc_stall           = 1'b1;
      bus.if2id_stall_o  = 1'b1;
      bus.id2ex_stall_o  = 1'b1;
      bus.ex2mem_stall_o = 1'b1;
      bus.mem2wb_flush_o = 1'b1;
    end else begin
      unique case (state_q)
        ST_KILL: begin
          pc_stall          = 1'b1;
          bus.if2id_flush_o = 1'b1;
        end
        ST_MDU: begin
          if (!bus.mdu_done_i) begin
            pc_stall           = 1'b1;
            bus.if2id_stall_o  = 1'b1;
            bus.id2ex_stall_o  = 1'b1;
            bus.ex2mem_flush_o = 1'b1;
          end
        end
        ST_RUN: begin
          if (mdu_issue) begin
            bus.mdu_start_o    = 1'b1;
            pc_stall           = 1'b1;
            bus.if2id_stall_o  = 1'b1;
            bus.id2ex_stall_o  = 1'b1;
            bus.ex2mem_flush_o = 1'b1;
          end else if (bus.ex_redirect_i) begin
            bus.if2id_flush_o = 1'b1;
            bus.id2ex_flush_o = 1'b1;
          end else if (load_use) begin
            pc_stall          = 1'b1;
            bus.if2id_stall_o = 1'b1;
            bus.id2ex_flush_o = 1'b1;
          end else if (!bus.if_ready_i) begin
            pc_stall          = 1'b1;
            bus.if2id_flush_o = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating count of PC-stall cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  assign bus.pc_stall_o   = pc_stall;
  assign bus.ctrl_state_o = state_q;
  assign bus.stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a driver issues directed vectors and
// queues hand-computed expectations; a monitor pops and compares each cycle.
module tb_pipe_hazard_ctrl;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 4;

  // ctl bit order: pc,if2id_s,id2ex_s,ex2mem_s,if2id_f,id2ex_f,ex2mem_f,mem2wb_f,start
  localparam logic [8:0] NONE  = 9'b000000000;
  localparam logic [8:0] MEMW  = 9'b111100010;
  localparam logic [8:0] KILLO = 9'b100010000;
  localparam logic [8:0] IFW   = 9'b100010000;
  localparam logic [8:0] MDUW  = 9'b111000100;
  localparam logic [8:0] MDUS  = 9'b111000101;
  localparam logic [8:0] REDIR = 9'b000011000;
  localparam logic [8:0] LU    = 9'b110001000;
  localparam logic [8:0] RSTO  = 9'b000011110;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_IDX_W(RW), .CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(.REG_IDX_W(RW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct packed {
    logic [8:0]    ctl;
    logic [1:0]    st;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic          s_rst, s_rs1_en, s_rs2_en, s_valid, s_memrd, s_mdu, s_rd_en;
  logic          s_redir, s_ifr, s_mreq, s_mrdy, s_done;
  logic [RW-1:0] s_rs1, s_rs2, s_rd;

  task automatic clr();
    s_rst = 1'b0; s_rs1_en = 1'b0; s_rs2_en = 1'b0; s_valid = 1'b0;
    s_memrd = 1'b0; s_mdu = 1'b0; s_rd_en = 1'b0; s_redir = 1'b0;
    s_ifr = 1'b1; s_mreq = 1'b0; s_mrdy = 1'b0; s_done = 1'b0;
    s_rs1 = '0; s_rs2 = '0; s_rd = '0;
  endtask

  task automatic drive();
    rst                  = s_rst;
    bus.id_rs1_en_i      = s_rs1_en;
    bus.id_rs1_index_i   = s_rs1;
    bus.id_rs2_en_i      = s_rs2_en;
    bus.id_rs2_index_i   = s_rs2;
    bus.id2ex_valid_i    = s_valid;
    bus.id2ex_mem_read_i = s_memrd;
    bus.id2ex_mdu_i      = s_mdu;
    bus.id2ex_rd_en_i    = s_rd_en;
    bus.id2ex_rd_index_i = s_rd;
    bus.ex_redirect_i    = s_redir;
    bus.if_ready_i       = s_ifr;
    bus.mem_req_i        = s_mreq;
    bus.mem_ready_i      = s_mrdy;
    bus.mdu_done_i       = s_done;
  endtask

  // Apply staged inputs for one cycle and queue what the DUT must show in it
  task automatic step(input logic [8:0] ctl, input logic [1:0] st, input logic [CW-1:0] cnt);
    exp_t e;
    @(posedge clk);
    #1;
    drive();
    e.ctl = ctl; e.st = st; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle
  initial begin
    exp_t e;
    logic [8:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {bus.pc_stall_o, bus.if2id_stall_o, bus.id2ex_stall_o, bus.ex2mem_stall_o,
               bus.if2id_flush_o, bus.id2ex_flush_o, bus.ex2mem_flush_o,
               bus.mem2wb_flush_o, bus.mdu_start_o};
        n_vec++;
        if (got !== e.ctl) begin
          n_err++;
          $display("FAIL ctl vec %0d: got %b expected %b", n_vec, got, e.ctl);
        end
        if (bus.ctrl_state_o !== e.st) begin
          n_err++;
          $display("FAIL state vec %0d: got %0d expected %0d", n_vec, bus.ctrl_state_o, e.st);
        end
        if (bus.stall_cnt_o !== e.cnt) begin
          n_err++;
          $display("FAIL stall_cnt vec %0d: got %0d expected %0d", n_vec, bus.stall_cnt_o, e.cnt);
        end
      end
    end
  end

  initial begin
    clr();
    s_rst = 1'b1;
    drive();
    repeat (2) @(posedge clk);

    // Reset state
    s_rst = 1'b1;                                   step(RSTO,  2'd0, 4'd0);
    clr();                                          step(NONE,  2'd0, 4'd0);

    // Load-use via rs1, then bubble reaches EX
    s_valid = 1; s_memrd = 1; s_rd_en = 1; s_rd = 5;
    s_rs1_en = 1; s_rs1 = 5; s_rs2_en = 1; s_rs2 = 1;   step(LU,    2'd0, 4'd0);
    s_valid = 0;                                    step(NONE,  2'd0, 4'd1);
    // No false stalls: rd=x0, rd not read, bubble in EX, sources disabled
    s_valid = 1; s_rd = 0; s_rs1 = 0;               step(NONE,  2'd0, 4'd1);
    s_rd = 5; s_rs1 = 6; s_rs2 = 7;                 step(NONE,  2'd0, 4'd1);
    s_rs1 = 5; s_valid = 0;                         step(NONE,  2'd0, 4'd1);
    s_valid = 1; s_rs1_en = 0; s_rs2_en = 0;        step(NONE,  2'd0, 4'd1);
    // Load-use via rs2
    s_rs1_en = 1; s_rs1 = 3; s_rs2_en = 1; s_rs2 = 5;   step(LU,    2'd0, 4'd1);

    // MDU: done rises 4 cycles after start
    clr(); s_valid = 1; s_mdu = 1;                  step(MDUS,  2'd0, 4'd2);
                                                    step(MDUW,  2'd1, 4'd3);
                                                    step(MDUW,  2'd1, 4'd4);
                                                    step(MDUW,  2'd1, 4'd5);
    s_done = 1;                                     step(NONE,  2'd1, 4'd6);
    s_valid = 0; s_mdu = 0;                         step(NONE,  2'd0, 4'd6);

    // Redirect with fetch outstanding; response arrives 3 cycles later
    clr(); s_redir = 1; s_ifr = 0;                  step(REDIR, 2'd0, 4'd6);
    s_redir = 0;                                    step(KILLO, 2'd2, 4'd6);
                                                    step(KILLO, 2'd2, 4'd7);
    s_ifr = 1;                                      step(KILLO, 2'd2, 4'd8);
                                                    step(NONE,  2'd0, 4'd9);
    // Plain fetch wait
    s_ifr = 0;                                      step(IFW,   2'd0, 4'd9);
    s_ifr = 1;                                      step(NONE,  2'd0, 4'd10);

    // Memory wait overlapping a redirect
    s_mreq = 1; s_mrdy = 0; s_redir = 1;            step(MEMW,  2'd0, 4'd10);
                                                    step(MEMW,  2'd0, 4'd11);
    s_mrdy = 1;                                     step(REDIR, 2'd0, 4'd12);
    clr();                                          step(NONE,  2'd0, 4'd12);

    // MDU done coinciding with a memory wait
    s_valid = 1; s_mdu = 1;                         step(MDUS,  2'd0, 4'd12);
    s_done = 1; s_mreq = 1; s_mrdy = 0;             step(MEMW,  2'd1, 4'd13);
    s_mrdy = 1;                                     step(NONE,  2'd1, 4'd14);
    s_valid = 0; s_mdu = 0; s_mreq = 0;             step(NONE,  2'd0, 4'd14);

    // Counter saturation
    clr(); s_ifr = 0;                               step(IFW,   2'd0, 4'd14);
                                                    step(IFW,   2'd0, 4'd15);
                                                    step(IFW,   2'd0, 4'd15);

    // Reset mid-MDU
    clr(); s_valid = 1; s_mdu = 1;                  step(MDUS,  2'd0, 4'd15);
                                                    step(MDUW,  2'd1, 4'd15);
    s_rst = 1;                                      step(RSTO,  2'd1, 4'd15);
    clr();                                          step(NONE,  2'd0, 4'd0);

    // Reset mid-KILL
    s_redir = 1; s_ifr = 0;                         step(REDIR, 2'd0, 4'd0);
    s_redir = 0; s_rst = 1;                         step(RSTO,  2'd2, 4'd0);
    clr();                                          step(NONE,  2'd0, 4'd0);

    // Done already high at start: earliest release
    s_valid = 1; s_mdu = 1; s_done = 1;             step(MDUS,  2'd0, 4'd0);
                                                    step(NONE,  2'd1, 4'd1);
    s_valid = 0; s_mdu = 0;                         step(NONE,  2'd0, 4'd1);

    // Redirect outranks load-use
    clr(); s_redir = 1; s_valid = 1; s_memrd = 1; s_rd_en = 1; s_rd = 5;
    s_rs1_en = 1; s_rs1 = 5;                        step(REDIR, 2'd0, 4'd1);
    clr();                                          step(NONE,  2'd0, 4'd1);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
